// File: rtl/down_timer.sv
// down_timer: loadable down-counter with prescaler, hold/resume and optional
// auto-reload. Emits a registered one-cycle done pulse at terminal count.
//
// Control inputs are level-sampled every rising edge; there is no handshake.
// Priority on each edge is reset > load > stop > start > counting. A stop
// that is asserted alongside start always keeps the counter from running.
module down_timer #(
   parameter int WIDTH    = 4,
   parameter int PRESCALE = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             load,
   input  logic [WIDTH-1:0] in,
   input  logic             start,
   input  logic             stop,
   input  logic             auto_reload,
   output logic [WIDTH-1:0] out,
   output logic             busy,
   output logic             done,
   output logic             zero,
   output logic [1:0]       state_dbg
);

   // Prescaler width is clog2(PRESCALE) but never narrower than one bit.
   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PS_LAST = PW'(PRESCALE - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t           state, state_n;
   logic [WIDTH-1:0] count, count_n;
   logic [WIDTH-1:0] reload_val, reload_n;
   logic [PW-1:0]    prescaler, prescaler_n;
   logic             done_n;
   logic             tick;

   // A tick is the last prescaler cycle of a decrement period.
   assign tick = (prescaler == PS_LAST);

   // State register: all timer state updates here, cleared by reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         reload_val <= '0;
         prescaler  <= '0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         count      <= count_n;
         reload_val <= reload_n;
         prescaler  <= prescaler_n;
         done       <= done_n;
      end
   end

   // Next-state logic: load overrides everything, then per-state behaviour.
   always_comb begin
      state_n     = state;
      count_n     = count;
      reload_n    = reload_val;
      prescaler_n = prescaler;
      done_n      = 1'b0;
      if (load) begin
         // Load aborts any run silently; a fresh start is needed afterwards.
         count_n     = in;
         reload_n    = in;
         prescaler_n = '0;
         state_n     = IDLE;
      end else begin
         case (state)
            IDLE: begin
               // Starting from zero would underflow, so it is refused.
               if (!stop && start && (count != '0)) begin
                  state_n     = RUN;
                  prescaler_n = '0;
               end
            end
            HOLD: begin
               // Resume mid-period: the prescaler keeps its frozen value.
               if (!stop && start) begin
                  state_n = RUN;
               end
            end
            RUN: begin
               if (stop) begin
                  state_n = HOLD;
               end else if (tick) begin
                  prescaler_n = '0;
                  if (count > WIDTH'(1)) begin
                     count_n = count - WIDTH'(1);
                  end else if (auto_reload) begin
                     count_n = reload_val;
                     done_n  = 1'b1;
                  end else begin
                     count_n = '0;
                     state_n = IDLE;
                     done_n  = 1'b1;
                  end
               end else begin
                  prescaler_n = prescaler + PW'(1);
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   assign out       = count;
   assign busy      = (state == RUN);
   assign zero      = (count == '0);
   assign state_dbg = state;

endmodule

// File: tb/tb_down_timer.sv
// Bench for down_timer: a vector table on a PRESCALE=1 instance plus
// hand-written multi-cycle sequences on PRESCALE=1/3/4 instances. Expected
// values are queued when stimulus is driven and compared after the edge.
module tb_down_timer;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       reset = 1'b1;
   logic       load = 1'b0;
   logic [3:0] in = 4'd0;
   logic       start = 1'b0;
   logic       stop = 1'b0;
   logic       auto_reload = 1'b0;

   logic [3:0] out1, out3, out4;
   logic       busy1, busy3, busy4;
   logic       done1, done3, done4;
   logic       zero1, zero3, zero4;
   logic [1:0] st1, st3, st4;

   down_timer #(.WIDTH(4), .PRESCALE(1)) u_p1 (
      .clock(clock), .reset(reset), .load(load), .in(in), .start(start),
      .stop(stop), .auto_reload(auto_reload), .out(out1), .busy(busy1),
      .done(done1), .zero(zero1), .state_dbg(st1));

   down_timer #(.WIDTH(4), .PRESCALE(3)) u_p3 (
      .clock(clock), .reset(reset), .load(load), .in(in), .start(start),
      .stop(stop), .auto_reload(auto_reload), .out(out3), .busy(busy3),
      .done(done3), .zero(zero3), .state_dbg(st3));

   down_timer #(.WIDTH(4), .PRESCALE(4)) u_p4 (
      .clock(clock), .reset(reset), .load(load), .in(in), .start(start),
      .stop(stop), .auto_reload(auto_reload), .out(out4), .busy(busy4),
      .done(done4), .zero(zero4), .state_dbg(st4));

   // ---------------- scoreboard ----------------
   // Expected word: {out[3:0], busy, done, zero, state[1:0]}
   logic [8:0] exp_q[$];
   int n_checks = 0;
   int n_fail   = 0;

   function automatic logic [8:0] pk(input int o, input logic b,
                                     input logic d, input logic [1:0] s);
      logic [3:0] o4;
      o4 = o[3:0];
      return {o4, b, d, (o4 == 4'd0), s};
   endfunction

   function automatic logic [8:0] actual(input int sel);
      case (sel)
         3:       return {out3, busy3, done3, zero3, st3};
         4:       return {out4, busy4, done4, zero4, st4};
         default: return {out1, busy1, done1, zero1, st1};
      endcase
   endfunction

   // ---------------- driver ----------------
   task automatic step(input int sel, input logic rst, input logic ld,
                       input logic [3:0] d, input logic st, input logic sp,
                       input logic ar, input logic [8:0] e, input string name);
      logic [8:0] got, want;
      @(negedge clock);
      reset = rst; load = ld; in = d; start = st; stop = sp; auto_reload = ar;
      exp_q.push_back(e);
      @(posedge clock);
      #1;
      want = exp_q.pop_front();
      got  = actual(sel);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s (p%0d): got out=%0d busy=%b done=%b zero=%b st=%0d, want out=%0d busy=%b done=%b zero=%b st=%0d",
                  name, sel, got[8:5], got[4], got[3], got[2], got[1:0],
                  want[8:5], want[4], want[3], want[2], want[1:0]);
      end
   endtask

   task automatic idle(input int sel, input logic ar, input logic [8:0] e,
                       input string name);
      step(sel, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, ar, e, name);
   endtask

   // Load N, start, then count down to done with no interruptions.
   task automatic run_seq(input int sel, input int n, input int p);
      int o;
      logic fin;
      step(sel, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, S_IDLE), "seq_reset");
      step(sel, 1'b0, 1'b1, 4'(n), 1'b0, 1'b0, 1'b0, pk(n, 0, 0, S_IDLE), "seq_load");
      step(sel, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, pk(n, 1, 0, S_RUN), "seq_start");
      for (int k = 1; k <= n * p; k++) begin
         o   = n - k / p;
         fin = (k == n * p);
         idle(sel, 1'b0, pk(o, !fin, fin, fin ? S_IDLE : S_RUN), "seq_count");
      end
      idle(sel, 1'b0, pk(0, 0, 0, S_IDLE), "seq_after_done");
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic       rst, ld;
      logic [3:0] d;
      logic       st, sp, ar;
      int         e_out;
      logic       e_busy, e_done;
      logic [1:0] e_st;
      string      name;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(input logic rst, input logic ld, input logic [3:0] d,
                               input logic st, input logic sp, input logic ar,
                               input int eo, input logic eb, input logic ed,
                               input logic [1:0] es, input string name);
      vec_t v;
      v.rst = rst; v.ld = ld; v.d = d; v.st = st; v.sp = sp; v.ar = ar;
      v.e_out = eo; v.e_busy = eb; v.e_done = ed; v.e_st = es; v.name = name;
      return v;
   endfunction

   initial begin
      //             rst ld  d      st  sp  ar  out busy done state
      tbl.push_back(mk(1, 0, 4'd0,  0, 0, 0,  0, 0, 0, S_IDLE, "reset"));
      tbl.push_back(mk(0, 1, 4'd3,  0, 0, 0,  3, 0, 0, S_IDLE, "load3"));
      tbl.push_back(mk(0, 0, 4'd0,  1, 0, 0,  3, 1, 0, S_RUN,  "start3"));
      tbl.push_back(mk(0, 0, 4'd0,  0, 0, 0,  2, 1, 0, S_RUN,  "cnt2"));
      tbl.push_back(mk(0, 0, 4'd0,  0, 0, 0,  1, 1, 0, S_RUN,  "cnt1"));
      tbl.push_back(mk(0, 0, 4'd0,  0, 0, 0,  0, 0, 1, S_IDLE, "terminal"));
      tbl.push_back(mk(0, 0, 4'd0,  0, 0, 0,  0, 0, 0, S_IDLE, "done_one_cycle"));
      tbl.push_back(mk(0, 0, 4'd0,  1, 0, 0,  0, 0, 0, S_IDLE, "start_at_zero"));
      tbl.push_back(mk(0, 1, 4'd15, 1, 0, 0, 15, 0, 0, S_IDLE, "load_start_same"));
      tbl.push_back(mk(0, 0, 4'd0,  1, 0, 0, 15, 1, 0, S_RUN,  "start15"));
      tbl.push_back(mk(0, 0, 4'd0,  0, 0, 0, 14, 1, 0, S_RUN,  "cnt14"));
      tbl.push_back(mk(0, 1, 4'd3,  0, 0, 0,  3, 0, 0, S_IDLE, "load_in_run"));
      tbl.push_back(mk(0, 0, 4'd0,  1, 0, 0,  3, 1, 0, S_RUN,  "restart3"));
      tbl.push_back(mk(0, 0, 4'd0,  0, 0, 0,  2, 1, 0, S_RUN,  "cnt2b"));
      tbl.push_back(mk(0, 1, 4'd9,  0, 0, 0,  9, 0, 0, S_IDLE, "load_at_out2"));
      tbl.push_back(mk(0, 0, 4'd0,  0, 0, 0,  9, 0, 0, S_IDLE, "no_done_after_load"));
      tbl.push_back(mk(0, 0, 4'd0,  1, 0, 0,  9, 1, 0, S_RUN,  "start9"));
      tbl.push_back(mk(0, 0, 4'd0,  1, 1, 0,  9, 0, 0, S_HOLD, "stop_beats_start"));
      tbl.push_back(mk(0, 0, 4'd0,  0, 0, 0,  9, 0, 0, S_HOLD, "hold"));
      tbl.push_back(mk(0, 0, 4'd0,  0, 1, 0,  9, 0, 0, S_HOLD, "stop_in_hold"));
      tbl.push_back(mk(0, 0, 4'd0,  1, 0, 0,  9, 1, 0, S_RUN,  "resume"));
      tbl.push_back(mk(0, 0, 4'd0,  0, 0, 0,  8, 1, 0, S_RUN,  "cnt8"));
      tbl.push_back(mk(0, 1, 4'd3,  0, 0, 1,  3, 0, 0, S_IDLE, "ar_load3"));
      tbl.push_back(mk(0, 0, 4'd0,  1, 0, 1,  3, 1, 0, S_RUN,  "ar_start"));
      for (int r = 0; r < 3; r++) begin
         tbl.push_back(mk(0, 0, 4'd0, 0, 0, 1, 2, 1, 0, S_RUN, "ar_cnt2"));
         tbl.push_back(mk(0, 0, 4'd0, 0, 0, 1, 1, 1, 0, S_RUN, "ar_cnt1"));
         tbl.push_back(mk(0, 0, 4'd0, 0, 0, 1, 3, 1, 1, S_RUN, "ar_reload"));
      end
      tbl.push_back(mk(1, 0, 4'd0,  0, 0, 1,  0, 0, 0, S_IDLE, "reset_in_ar"));

      foreach (tbl[i]) begin
         step(1, tbl[i].rst, tbl[i].ld, tbl[i].d, tbl[i].st, tbl[i].sp, tbl[i].ar,
              pk(tbl[i].e_out, tbl[i].e_busy, tbl[i].e_done, tbl[i].e_st), tbl[i].name);
      end

      // Full-range count with no wrap, and the prescaled latency case.
      run_seq(1, 15, 1);
      run_seq(4, 2, 4);

      // PRESCALE=3, load 5: stop mid-period, hold, resume. Five frozen edges
      // (stop, three hold cycles, resume) delay done from edge 15 to edge 20.
      step(3, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, S_IDLE), "h_reset");
      step(3, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, pk(5, 0, 0, S_IDLE), "h_load");
      step(3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, pk(5, 1, 0, S_RUN), "h_start");
      for (int k = 1; k <= 4; k++) idle(3, 1'b0, pk(5 - k / 3, 1, 0, S_RUN), "h_run");
      step(3, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, pk(4, 0, 0, S_HOLD), "h_stop");
      for (int k = 0; k < 3; k++) idle(3, 1'b0, pk(4, 0, 0, S_HOLD), "h_frozen");
      step(3, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, pk(4, 1, 0, S_RUN), "h_resume");
      for (int a = 5; a <= 15; a++) begin
         idle(3, 1'b0, pk(5 - a / 3, (a != 15), (a == 15), (a == 15) ? S_IDLE : S_RUN),
              "h_after");
      end

      // Reset in the middle of a run at out=6, then a refused start.
      step(1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, pk(0, 0, 0, S_IDLE), "r_reset");
      step(1, 1'b0, 1'b1, 4'd8, 1'b0, 1'b0, 1'b0, pk(8, 0, 0, S_IDLE), "r_load");
      step(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, pk(8, 1, 0, S_RUN), "r_start");
      idle(1, 1'b0, pk(7, 1, 0, S_RUN), "r_cnt7");
      idle(1, 1'b0, pk(6, 1, 0, S_RUN), "r_cnt6");
      step(1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, pk(0, 0, 0, S_IDLE), "r_midrun_reset");
      step(1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0, pk(0, 0, 0, S_IDLE), "r_start_ignored");

      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/down_timer.md
# down_timer

Programmable down-counting timer, the counting-down counterpart to the team's 4-bit loadable up-counter. It loads a start value, decrements it once every PRESCALE clocks while running, and flags terminal count with a one-cycle `done` pulse. Optional auto-reload turns it into a periodic tick generator. It sits beside the up-counter in the control datapath and produces timeouts and periodic strobes for downstream FSMs.

## Interface
- WIDTH, 4, counter and load-value width; must be ≥ 1
- PRESCALE, 1, clock cycles per decrement; must be ≥ 1; prescaler register width is clog2(PRESCALE), minimum 1 bit
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  reset reset, synchronous, active-high; clock clock
- load  input  1  capture `in` into the count and reload registers
- in  input  WIDTH  load value
- start  input  1  begin counting, or resume counting after a hold
- stop  input  1  pause counting; count and prescaler are frozen
- auto_reload  input  1  at terminal count, reload and keep running instead of stopping
- out  output  WIDTH  current count, registered
- busy  output  1  high while in RUN
- done  output  1  registered one-cycle pulse at terminal count
- zero  output  1  combinational, (out == 0)

## Operation
- Internal registers: count (drives `out`), reload_val, prescaler, state ∈ {IDLE, RUN, HOLD}.
- Priority per edge: reset > load > stop > start > count.
- reset: count=0, reload_val=0, prescaler=0, state=IDLE, done=0.
- load, any state: count=in, reload_val=in, prescaler=0, state=IDLE. Aborts a run. No `done` is generated.
- stop:
  - RUN → HOLD, with count and prescaler held.
  - Ignored in IDLE and HOLD.
- start:
  - IDLE with count≠0 → RUN, prescaler=0.
  - HOLD → RUN, prescaler kept; resumes mid-period.
  - IDLE with count==0: ignored; remains IDLE and no `done`.
  - RUN: ignored.
- RUN, no higher-priority input: prescaler increments. When prescaler==PRESCALE-1 a tick occurs and prescaler wraps to 0.
- On a tick:
  - count>1: count=count-1.
  - count==1, auto_reload=0: count=0, state=IDLE, done=1 next cycle.
  - count==1, auto_reload=1: count=reload_val, state stays RUN, done=1 next cycle.
  - auto_reload is sampled only on the terminal tick.
- Arithmetic is unsigned and modulo 2^WIDTH. Count never underflows, because RUN is never entered with count==0.
- done defaults to 0 on every edge; it is high for exactly one cycle per terminal count.
- busy = (state==RUN). HOLD reports busy=0.

## Timing
- Reset values: out=0, busy=0, done=0, zero=1.
- Latency: count N loaded and start sampled at edge t gives:
  - busy=1 after edge t;
  - first decrement at edge t+PRESCALE;
  - out=0 and done=1 after edge t+N·PRESCALE, in the same cycle.
- Auto-reload period is reload_val·PRESCALE cycles between done pulses; out never shows 0.
- Simultaneous events:
  - load+start: load wins, state IDLE; a later start is required.
  - stop+start in RUN: stop wins.
  - stop on a tick cycle: no decrement.
  - reset with anything: reset wins.
- Reset mid-run clears everything within one edge, and no done pulse is emitted.
- Maximum load value 2^WIDTH-1 counts fully down; there is no wrap.

## Test plan
- PRESCALE=1, WIDTH=4: load 3, then start → out 3,2,1,0 on successive cycles; done=1 only in the out=0 cycle; busy falls with it; zero=1 after.
- PRESCALE=4: load 2, start → out stays 2 for 4 cycles, then 1 for 4, then 0 with done; done 8 cycles after the start edge.
- auto_reload=1, load 3, start, run 10 cycles (PRESCALE=1) → out 2,1,3,2,1,3,…; done pulses every 3 cycles; busy stays high; out never 0.
- PRESCALE=3, load 5, start, stop after 4 cycles, hold 5 cycles, start → out frozen at 4 with prescaler mid-period; resumes and done arrives exactly 5 cycles late versus the uninterrupted run.
- Boundaries:
  - start with out=0 → stays IDLE, no done.
  - load 15 with start same cycle → IDLE, out=15.
  - load during RUN at out=2 → out=in, IDLE, no done.
- Reset asserted mid-run with out=6 → next cycle out=0, busy=0, done=0, zero=1; subsequent start is ignored.
